// File: rtl/brc_pkg.sv
// Shared definitions for the branch-resolution stage.
//   F3_*         : RV32 branch funct3 encodings
//   brc_state_e  : resolver FSM states
package brc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    FLUSH
  } brc_state_e;

endpackage

// File: rtl/brc_decode.sv
// Combinational branch decision from comparator flags.
//   i_funct3     : branch funct3
//   i_brc_equal  : rs1 == rs2
//   i_brc_less   : rs1 < rs2 (unsigned)
//   i_rs1_msb    : sign bit of rs1
//   i_rs2_msb    : sign bit of rs2
//   o_taken      : branch condition holds
//   o_illegal    : funct3 is not a branch encoding
module brc_decode
  import brc_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_brc_equal,
  input  logic       i_brc_less,
  input  logic       i_rs1_msb,
  input  logic       i_rs2_msb,
  output logic       o_taken,
  output logic       o_illegal
);

  logic lt_s;

  // Differing signs decide the signed order on their own; otherwise the
  // unsigned result is also the signed result.
  assign lt_s = (i_rs1_msb != i_rs2_msb) ? i_rs1_msb : i_brc_less;

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_funct3)
      F3_BEQ:  o_taken = i_brc_equal;
      F3_BNE:  o_taken = !i_brc_equal;
      F3_BLT:  o_taken = lt_s;
      F3_BGE:  o_taken = !lt_s;
      F3_BLTU: o_taken = i_brc_less;
      F3_BGEU: o_taken = !i_brc_less;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/brc_resolver.sv
// Registered branch-resolution stage between the comparator and PC/fetch.
//   i_clk, i_rst                 : clock, async active-high reset
//   i_req_valid / o_req_ready    : request handshake (accepted only in IDLE)
//   i_funct3, i_brc_equal, i_brc_less, i_rs1_msb, i_rs2_msb : decision inputs
//   i_pc, i_imm                  : branch PC and sign-extended B-immediate
//   o_res_valid / i_res_ready    : result handshake
//   o_taken, o_target, o_illegal : captured result, stable while o_res_valid
//   o_flush                      : high FLUSH_CYCLES cycles after a taken result
//   o_brc_count, o_taken_count   : saturating statistics
module brc_resolver
  import brc_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned PC_SIZE      = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_SIZE     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [2:0]          i_funct3,
  input  logic                i_brc_equal,
  input  logic                i_brc_less,
  input  logic                i_rs1_msb,
  input  logic                i_rs2_msb,
  input  logic [PC_SIZE-1:0]  i_pc,
  input  logic [PC_SIZE-1:0]  i_imm,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic                o_taken,
  output logic [PC_SIZE-1:0]  o_target,
  output logic                o_illegal,
  output logic                o_flush,
  output logic [CNT_SIZE-1:0] o_brc_count,
  output logic [CNT_SIZE-1:0] o_taken_count
);

  // Flush counter only needs to hold FLUSH_CYCLES-1.
  localparam int unsigned FcW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  if (DATA_SIZE < 1 || PC_SIZE < 3 || CNT_SIZE < 1) begin : g_param_check
    $fatal(1, "brc_resolver: bad parameter");
  end

  brc_state_e          state_q;
  logic                taken_q;
  logic                illegal_q;
  logic [PC_SIZE-1:0]  target_q;
  logic [FcW-1:0]      fc_q;
  logic [CNT_SIZE-1:0] brc_cnt_q;
  logic [CNT_SIZE-1:0] taken_cnt_q;

  logic                dec_taken;
  logic                dec_illegal;
  logic [PC_SIZE-1:0]  target_nxt;

  brc_decode u_decode (
    .i_funct3    (i_funct3),
    .i_brc_equal (i_brc_equal),
    .i_brc_less  (i_brc_less),
    .i_rs1_msb   (i_rs1_msb),
    .i_rs2_msb   (i_rs2_msb),
    .o_taken     (dec_taken),
    .o_illegal   (dec_illegal)
  );

  // Wraps modulo 2^PC_SIZE; carry-out is dropped.
  assign target_nxt = dec_taken ? (i_pc + i_imm) : (i_pc + PC_SIZE'(4));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      target_q    <= '0;
      fc_q        <= '0;
      brc_cnt_q   <= '0;
      taken_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            taken_q   <= dec_taken;
            illegal_q <= dec_illegal;
            target_q  <= target_nxt;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (i_res_ready) begin
            if (!illegal_q && (brc_cnt_q != '1)) begin
              brc_cnt_q <= brc_cnt_q + 1'b1;
            end
            if (taken_q && (taken_cnt_q != '1)) begin
              taken_cnt_q <= taken_cnt_q + 1'b1;
            end
            if (taken_q && (FLUSH_CYCLES > 0)) begin
              fc_q    <= FcW'(FLUSH_CYCLES - 1);
              state_q <= FLUSH;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (fc_q == '0) begin
            state_q <= IDLE;
          end else begin
            fc_q <= fc_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake/flush outputs decode directly from the state register.
  assign o_req_ready   = (state_q == IDLE);
  assign o_res_valid   = (state_q == RESP);
  assign o_flush       = (state_q == FLUSH);
  assign o_taken       = taken_q;
  assign o_illegal     = illegal_q;
  assign o_target      = target_q;
  assign o_brc_count   = brc_cnt_q;
  assign o_taken_count = taken_cnt_q;

endmodule

// File: tb/tb_brc_resolver.sv
module tb_brc_resolver;

  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        i_req_valid, o_req_ready;
  logic [2:0]  i_funct3;
  logic        i_brc_equal, i_brc_less, i_rs1_msb, i_rs2_msb;
  logic [31:0] i_pc, i_imm;
  logic        o_res_valid, i_res_ready;
  logic        o_taken, o_illegal, o_flush;
  logic [31:0] o_target;
  logic [15:0] o_brc_count, o_taken_count;

  // Saturation DUT signals
  logic        s_req_valid, s_req_ready, s_res_valid, s_taken, s_illegal, s_flush;
  logic [31:0] s_target;
  logic [1:0]  s_brc_count, s_taken_count;

  brc_resolver #(
    .DATA_SIZE(32), .PC_SIZE(32), .FLUSH_CYCLES(FC), .CNT_SIZE(16)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_funct3(i_funct3), .i_brc_equal(i_brc_equal), .i_brc_less(i_brc_less),
    .i_rs1_msb(i_rs1_msb), .i_rs2_msb(i_rs2_msb), .i_pc(i_pc), .i_imm(i_imm),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_taken(o_taken), .o_target(o_target), .o_illegal(o_illegal), .o_flush(o_flush),
    .o_brc_count(o_brc_count), .o_taken_count(o_taken_count)
  );

  brc_resolver #(
    .DATA_SIZE(32), .PC_SIZE(32), .FLUSH_CYCLES(0), .CNT_SIZE(2)
  ) u_sat (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(s_req_valid), .o_req_ready(s_req_ready),
    .i_funct3(3'b000), .i_brc_equal(1'b1), .i_brc_less(1'b0),
    .i_rs1_msb(1'b0), .i_rs2_msb(1'b0), .i_pc(32'h0000_0400), .i_imm(32'h0000_0010),
    .o_res_valid(s_res_valid), .i_res_ready(1'b1),
    .o_taken(s_taken), .o_target(s_target), .o_illegal(s_illegal), .o_flush(s_flush),
    .o_brc_count(s_brc_count), .o_taken_count(s_taken_count)
  );

  typedef struct {
    logic        taken;
    logic        illegal;
    logic [31:0] target;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          flush_left = 0;
  bit          mon_en = 1'b0;
  bit          hold = 1'b1;
  logic [15:0] m_brc = '0;
  logic [15:0] m_tak = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: resolve the branch from the full operands.
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, b, pc, imm);
    exp_t e;
    e.illegal = 1'b0;
    case (f3)
      3'd0: e.taken = (a == b);
      3'd1: e.taken = (a != b);
      3'd4: e.taken = ($signed(a) < $signed(b));
      3'd5: e.taken = ($signed(a) >= $signed(b));
      3'd6: e.taken = (a < b);
      3'd7: e.taken = (a >= b);
      default: begin e.taken = 1'b0; e.illegal = 1'b1; end
    endcase
    e.target = e.taken ? pc + imm : pc + 32'd4;
    return e;
  endfunction

  // Consumer backpressure
  always @(posedge clk) begin
    #3;
    if (!hold) i_res_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  logic exp_ready, exp_flush;
  exp_t e_pop;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_flush = (flush_left > 0);
      exp_ready = (q.size() == 0) && (flush_left == 0);
      chk("flush", {31'd0, o_flush}, {31'd0, exp_flush});
      chk("req_ready", {31'd0, o_req_ready}, {31'd0, exp_ready});
      chk("res_valid", {31'd0, o_res_valid}, {31'd0, q.size() != 0});
      chk("brc_count", {16'd0, o_brc_count}, {16'd0, m_brc});
      chk("taken_count", {16'd0, o_taken_count}, {16'd0, m_tak});
      if (flush_left > 0) flush_left--;
      if (q.size() != 0) begin
        chk("taken", {31'd0, o_taken}, {31'd0, q[0].taken});
        chk("illegal", {31'd0, o_illegal}, {31'd0, q[0].illegal});
        chk("target", o_target, q[0].target);
        if (i_res_ready) begin
          e_pop = q.pop_front();
          if (e_pop.taken) flush_left = FC;
          if (!e_pop.illegal && m_brc != 16'hFFFF) m_brc++;
          if (e_pop.taken && m_tak != 16'hFFFF) m_tak++;
        end
      end
    end
  end

  task automatic send(input logic [2:0] f3, input logic [31:0] a, b, pc, imm, input bit stall);
    int n = 0;
    @(posedge clk); #1;
    while (!o_req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    i_funct3    = f3;
    i_brc_equal = (a == b);
    i_brc_less  = (a < b);
    i_rs1_msb   = a[31];
    i_rs2_msb   = b[31];
    i_pc        = pc;
    i_imm       = imm;
    i_req_valid = 1'b1;
    if (stall) begin
      hold        = 1'b1;
      i_res_ready = 1'b0;
    end
    @(posedge clk);
    q.push_back(model(f3, a, b, pc, imm));
    #1;
    if (stall) begin
      // A new request that must be ignored while the result is held.
      i_funct3    = 3'b001;
      i_brc_equal = ~i_brc_equal;
      i_brc_less  = ~i_brc_less;
      i_pc        = ~pc;
      repeat (5) @(posedge clk);
      #1;
      i_req_valid = 1'b0;
      hold        = 1'b0;
    end else begin
      i_req_valid = 1'b0;
    end
  endtask

  logic [31:0] ra, rb, rpc, rimm;
  logic [12:0] r13;
  int          n;

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b0; i_res_ready = 1'b0;
    i_funct3 = '0; i_brc_equal = 1'b0; i_brc_less = 1'b0;
    i_rs1_msb = 1'b0; i_rs2_msb = 1'b0; i_pc = '0; i_imm = '0;
    s_req_valid = 1'b0;
    #12;
    chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk("rst_taken", {31'd0, o_taken}, 32'd0);
    chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
    chk("rst_flush", {31'd0, o_flush}, 32'd0);
    chk("rst_target", o_target, 32'd0);
    chk("rst_counts", {o_brc_count, o_taken_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    send(3'b100, 32'h8000_0000, 32'd1, 32'h200, 32'h40, 1'b0);
    send(3'b110, 32'h8000_0000, 32'd1, 32'h200, 32'h40, 1'b0);
    send(3'b010, 32'd7, 32'd7, 32'h300, 32'h8, 1'b0);
    send(3'b011, 32'd1, 32'd9, 32'h304, 32'h8, 1'b0);
    send(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b0);
    send(3'b111, 32'd9, 32'd3, 32'h500, 32'hFFFF_FFC0, 1'b1);
    send(3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h600, 32'h10, 1'b0);

    // Randomized stream
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 32'h8000_0000;
        default: rb = $urandom;
      endcase
      rpc  = $urandom;
      r13  = 13'($urandom);
      rimm = {{19{r13[12]}}, r13[12:1], 1'b0};
      send(3'($urandom_range(0, 7)), ra, rb, rpc, rimm, (i % 20) == 10);
    end

    n = 0;
    while ((q.size() != 0 || flush_left != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", {31'd0, (q.size() == 0 && flush_left == 0)}, 32'd1);

    // Reset in the middle of a flush window
    send(3'b000, 32'd3, 32'd3, 32'h700, 32'h40, 1'b0);
    n = 0;
    while (flush_left == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("pre_rst_flush", {31'd0, o_flush}, 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_flush", {31'd0, o_flush}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, o_res_valid}, 32'd0);
    chk("mid_rst_counts", {o_brc_count, o_taken_count}, 32'd0);
    chk("mid_rst_target", o_target, 32'd0);
    q.delete();
    flush_left = 0;
    m_brc = '0;
    m_tak = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    mon_en = 1'b1;

    // Saturation on the 2-bit-counter instance (no flush window)
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("sat_req_ready", {31'd0, s_req_ready}, 32'd1);
      chk("sat_flush", {31'd0, s_flush}, 32'd0);
      s_req_valid = 1'b1;
      @(posedge clk); #1;
      s_req_valid = 1'b0;
      chk("sat_res_valid", {31'd0, s_res_valid}, 32'd1);
      chk("sat_taken", {31'd0, s_taken}, 32'd1);
      chk("sat_target", s_target, 32'h0000_0410);
      chk("sat_illegal", {31'd0, s_illegal}, 32'd0);
    end
    @(posedge clk); #1;
    chk("sat_brc_count", {30'd0, s_brc_count}, 32'd3);
    chk("sat_taken_count", {30'd0, s_taken_count}, 32'd3);

    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
